// File: rtl/pll_clk_sel_ctrl.sv
// Config-bus sequencer for the PLL clock-select tree: owns the BUFGMUX selects and the
// BUFGCE enable, and switches them glitch-free (gate off, wait, switch, wait, relock).
module pll_clk_sel_ctrl #(
  parameter int               SEL_W       = 4,
  parameter logic [SEL_W-1:0] DEFAULT_SEL = 4'b0100,
  parameter logic [15:0]      GATE_RST    = 16'd8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_req_i,
  output logic             cfg_ack_o,
  input  logic [1:0]       cfg_add_i,
  input  logic             cfg_wrn_i,
  input  logic [31:0]      cfg_data_i,
  output logic [31:0]      cfg_r_data_o,
  input  logic             pll_lock_i,
  output logic [SEL_W-1:0] clk_sel_o,
  output logic             clk_en_o,
  output logic             cfg_lock_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GATE_OFF  = 2'd1,
    ST_SWITCH    = 2'd2,
    ST_WAIT_LOCK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      gate_q, gate_d;
  logic [15:0]      swcnt_q, swcnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] clk_sel_q, clk_sel_d;
  logic             sticky_q, sticky_d;
  logic             pend_q, pend_d;
  logic             from_sw_q, from_sw_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             en_q, en_d;
  logic             cfg_lock_q, cfg_lock_d;
  logic             sync1_q, sync2_q, lock_prev_q;

  logic        lock_s;
  logic        busy_s;
  logic        sel_wr_s;
  logic        acc_s;
  logic        lock_fall_s;
  logic        cnt_done_s;
  logic [15:0] gate_eff_s;
  logic        data_unused;

  assign lock_s      = sync2_q;
  assign busy_s      = (state_q != ST_IDLE);
  assign sel_wr_s    = cfg_req_i & cfg_wrn_i & (cfg_add_i == 2'd0);
  // A SEL write must not land mid-sequence, so it waits for IDLE; everything else is served at once.
  assign acc_s       = cfg_req_i & ~ack_q & ~(sel_wr_s & busy_s);
  assign lock_fall_s = lock_prev_q & ~lock_s;
  assign gate_eff_s  = (gate_q == 16'd0) ? 16'd1 : gate_q;
  assign cnt_done_s  = ({1'b0, cnt_q} + 17'd1) >= {1'b0, gate_eff_s};
  assign data_unused = ^cfg_data_i[31:16];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gate_d     = gate_q;
    swcnt_d    = swcnt_q;
    sel_d      = sel_q;
    clk_sel_d  = clk_sel_q;
    sticky_d   = sticky_q;
    pend_d     = pend_q;
    from_sw_d  = from_sw_q;
    rdata_d    = rdata_q;
    ack_d      = acc_s;

    if (acc_s && !cfg_wrn_i) begin
      case (cfg_add_i)
        2'd0:    rdata_d = {{(32-SEL_W){1'b0}}, sel_q};
        2'd1:    rdata_d = {29'd0, sticky_q, busy_s, lock_s};
        2'd2:    rdata_d = {16'd0, gate_q};
        2'd3:    rdata_d = {16'd0, swcnt_q};
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end

    if (acc_s && cfg_wrn_i) begin
      case (cfg_add_i)
        2'd0:    sel_d = cfg_data_i[SEL_W-1:0];
        2'd1:    sticky_d = cfg_data_i[2] ? 1'b0 : sticky_q;
        2'd2:    gate_d = cfg_data_i[15:0];
        default: gate_d = gate_q;
      endcase
    end else begin
      sel_d = sel_q;
    end

    // Lock-loss updates come after the W1C decode so a simultaneous set wins.
    case (state_q)
      ST_IDLE: begin
        if (!lock_s) begin
          state_d  = ST_WAIT_LOCK;
          sticky_d = 1'b1;
          pend_d   = acc_s & sel_wr_s;
        end else if (acc_s && sel_wr_s) begin
          state_d = ST_GATE_OFF;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GATE_OFF: begin
        sticky_d = sticky_d | lock_fall_s;
        if (cnt_done_s) begin
          state_d   = ST_SWITCH;
          cnt_d     = 16'd0;
          clk_sel_d = sel_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SWITCH: begin
        sticky_d = sticky_d | lock_fall_s;
        if (cnt_done_s) begin
          state_d   = ST_WAIT_LOCK;
          cnt_d     = 16'd0;
          from_sw_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          from_sw_d = 1'b0;
          swcnt_d   = from_sw_q ? (swcnt_q + 16'd1) : swcnt_q;
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = ST_GATE_OFF;
            cnt_d   = 16'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    en_d       = (state_d == ST_IDLE);
    cfg_lock_d = sync1_q & (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= 16'd0;
      gate_q      <= GATE_RST;
      swcnt_q     <= 16'd0;
      sel_q       <= DEFAULT_SEL;
      clk_sel_q   <= DEFAULT_SEL;
      sticky_q    <= 1'b0;
      pend_q      <= 1'b0;
      from_sw_q   <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= 32'd0;
      en_q        <= 1'b0;
      cfg_lock_q  <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      lock_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gate_q      <= gate_d;
      swcnt_q     <= swcnt_d;
      sel_q       <= sel_d;
      clk_sel_q   <= clk_sel_d;
      sticky_q    <= sticky_d;
      pend_q      <= pend_d;
      from_sw_q   <= from_sw_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      en_q        <= en_d;
      cfg_lock_q  <= cfg_lock_d;
      sync1_q     <= pll_lock_i;
      sync2_q     <= sync1_q;
      lock_prev_q <= sync2_q;
    end
  end

  assign cfg_ack_o    = ack_q;
  assign cfg_r_data_o = rdata_q;
  assign clk_sel_o    = clk_sel_q;
  assign clk_en_o     = en_q;
  assign cfg_lock_o   = cfg_lock_q;

endmodule

// File: tb/tb_pll_clk_sel_ctrl.sv
// Directed bench for pll_clk_sel_ctrl: a register-access vector table plus
// hand-written cycle sequences for switching, stalling, lock loss, reset and wrap.
module tb_pll_clk_sel_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_req_i;
  logic        cfg_ack_o;
  logic [1:0]  cfg_add_i;
  logic        cfg_wrn_i;
  logic [31:0] cfg_data_i;
  logic [31:0] cfg_r_data_o;
  logic        pll_lock_i;
  logic [3:0]  clk_sel_o;
  logic        clk_en_o;
  logic        cfg_lock_o;

  int total = 0;
  int bad   = 0;

  pll_clk_sel_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_req_i    (cfg_req_i),
    .cfg_ack_o    (cfg_ack_o),
    .cfg_add_i    (cfg_add_i),
    .cfg_wrn_i    (cfg_wrn_i),
    .cfg_data_i   (cfg_data_i),
    .cfg_r_data_o (cfg_r_data_o),
    .pll_lock_i   (pll_lock_i),
    .clk_sel_o    (clk_sel_o),
    .clk_en_o     (clk_en_o),
    .cfg_lock_o   (cfg_lock_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  a;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Full transaction: hold req until ack, then confirm the ack lasts one cycle.
  task automatic xfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    cfg_add_i  = a;
    cfg_wrn_i  = w;
    cfg_data_i = d;
    cfg_req_i  = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cfg_ack_o && lat < 200);
    chk("ack_seen", {31'd0, cfg_ack_o}, 32'd1);
    rd = cfg_r_data_o;
    tick();
    chk("ack_one_cycle", {31'd0, cfg_ack_o}, 32'd0);
    cfg_req_i = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    xfer(a, 1'b0, 32'd0, rd, lat);
    chk(name, rd, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    xfer(a, 1'b1, d, rd, lat);
  endtask

  task automatic wait_en();
    int n = 0;
    while (!clk_en_o && n < 100) begin
      tick();
      n++;
    end
    chk("en_restore", {31'd0, clk_en_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[12];
    logic [31:0] rd;
    int          lat;
    int          exp_swcnt;

    vecs[0]  = '{2'd0, 1'b0, 32'd0,          32'h4};
    vecs[1]  = '{2'd1, 1'b0, 32'd0,          32'h1};
    vecs[2]  = '{2'd2, 1'b0, 32'd0,          32'h8};
    vecs[3]  = '{2'd3, 1'b0, 32'd0,          32'h0};
    vecs[4]  = '{2'd2, 1'b1, 32'hABC12345,   32'h0};
    vecs[5]  = '{2'd2, 1'b0, 32'd0,          32'h2345};
    vecs[6]  = '{2'd3, 1'b1, 32'h0000FFFF,   32'h2345};
    vecs[7]  = '{2'd3, 1'b0, 32'd0,          32'h0};
    vecs[8]  = '{2'd1, 1'b1, 32'h3,          32'h0};
    vecs[9]  = '{2'd1, 1'b0, 32'd0,          32'h1};
    vecs[10] = '{2'd2, 1'b1, 32'h3,          32'h1};
    vecs[11] = '{2'd2, 1'b0, 32'd0,          32'h3};

    rst_i      = 1'b1;
    pll_lock_i = 1'b1;
    cfg_req_i  = 1'b0;
    cfg_add_i  = 2'd0;
    cfg_wrn_i  = 1'b0;
    cfg_data_i = 32'd0;
    exp_swcnt  = 0;

    // Reset values, then lock-driven enable three edges after release.
    repeat (3) tick();
    chk("rst_ack",   {31'd0, cfg_ack_o}, 32'd0);
    chk("rst_rdata", cfg_r_data_o, 32'd0);
    chk("rst_sel",   {28'd0, clk_sel_o}, 32'h4);
    chk("rst_en",    {31'd0, clk_en_o}, 32'd0);
    chk("rst_lock",  {31'd0, cfg_lock_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    chk("rel1_en", {31'd0, clk_en_o}, 32'd0);
    tick();
    chk("rel2_en", {31'd0, clk_en_o}, 32'd0);
    tick();
    chk("rel3_en",   {31'd0, clk_en_o}, 32'd1);
    chk("rel3_lock", {31'd0, cfg_lock_o}, 32'd1);

    // Register access table; write rows check that r_data holds the last read.
    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].a, vecs[i].w, vecs[i].d, rd, lat);
      chk($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // GATE=3 switch to 0x1, traced cycle by cycle from the ack cycle.
    cfg_add_i  = 2'd0;
    cfg_wrn_i  = 1'b1;
    cfg_data_i = 32'h1;
    cfg_req_i  = 1'b1;
    tick();
    chk("sw_ack", {31'd0, cfg_ack_o}, 32'd1);
    chk("sw_en0", {31'd0, clk_en_o}, 32'd0);
    chk("sw_sel0", {28'd0, clk_sel_o}, 32'h4);
    cfg_req_i = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("sw_sel%0d", k), {28'd0, clk_sel_o}, (k < 3) ? 32'h4 : 32'h1);
      chk($sformatf("sw_en%0d", k),  {31'd0, clk_en_o},  (k >= 7) ? 32'd1 : 32'd0);
    end
    exp_swcnt = exp_swcnt + 1;
    rd_chk("swcnt_after_sw", 2'd3, exp_swcnt);

    // Second SEL write while busy is held off until IDLE.
    wr(2'd0, 32'h2);
    xfer(2'd0, 1'b1, 32'h8, rd, lat);
    chk("stall_latency", lat, 32'd7);
    wait_en();
    chk("stall_final_sel", {28'd0, clk_sel_o}, 32'h8);
    exp_swcnt = exp_swcnt + 2;
    rd_chk("swcnt_after_stall", 2'd3, exp_swcnt);

    // Lock loss in IDLE, sticky flag and its W1C clear.
    pll_lock_i = 1'b0;
    tick();
    chk("ll_en1", {31'd0, clk_en_o}, 32'd1);
    tick();
    chk("ll_en2", {31'd0, clk_en_o}, 32'd1);
    tick();
    chk("ll_en3",   {31'd0, clk_en_o}, 32'd0);
    chk("ll_lock3", {31'd0, cfg_lock_o}, 32'd0);
    rd_chk("ll_status", 2'd1, 32'h6);
    pll_lock_i = 1'b1;
    wait_en();
    chk("ll_relock", {31'd0, cfg_lock_o}, 32'd1);
    rd_chk("ll_status_sticky", 2'd1, 32'h5);
    wr(2'd1, 32'h4);
    rd_chk("ll_status_clr", 2'd1, 32'h1);
    rd_chk("ll_swcnt", 2'd3, exp_swcnt);

    // GATE=0 gives one-cycle phases; reset in SWITCH restores defaults.
    wr(2'd2, 32'h0);
    cfg_add_i  = 2'd0;
    cfg_wrn_i  = 1'b1;
    cfg_data_i = 32'h3;
    cfg_req_i  = 1'b1;
    tick();
    chk("g0_ack", {31'd0, cfg_ack_o}, 32'd1);
    cfg_req_i = 1'b0;
    tick();
    chk("g0_switch_sel", {28'd0, clk_sel_o}, 32'h3);
    chk("g0_switch_en",  {31'd0, clk_en_o}, 32'd0);
    rst_i = 1'b1;
    tick();
    chk("midrst_sel", {28'd0, clk_sel_o}, 32'h4);
    chk("midrst_en",  {31'd0, clk_en_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    exp_swcnt = 0;
    wait_en();
    rd_chk("midrst_gate",  2'd2, 32'h8);
    rd_chk("midrst_swcnt", 2'd3, exp_swcnt);
    rd_chk("midrst_selr",  2'd0, 32'h4);

    // SWCNT wrap with back-to-back switches at GATE=0.
    wr(2'd2, 32'h0);
    force dut.swcnt_q = 16'hFFFE;
    tick();
    release dut.swcnt_q;
    rd_chk("wrap_preload", 2'd3, 32'hFFFE);
    wr(2'd0, 32'h5);
    xfer(2'd0, 1'b1, 32'h6, rd, lat);
    chk("wrap_stall_latency", lat, 32'd3);
    wait_en();
    chk("wrap_sel", {28'd0, clk_sel_o}, 32'h6);
    rd_chk("wrap_swcnt", 2'd3, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
